// File: rtl/cdb_pkg.sv
// Common data bus shared types: the packet carried on the CDB and the default
// geometry used by the broadcaster, reservation stations and ROB.
package cdb_pkg;

    localparam int CDB_TAG_W   = 6;
    localparam int CDB_DATA_W  = 32;
    localparam int CDB_NUM_SRC = 4;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer for the CDB broadcaster. Pointers are log2(DEPTH)
// bits and wrap naturally; count is one bit wider so full and empty are distinct.
// Push and pop are gated internally against full/empty. Flush overrides both.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     flush,
    input  logic     push,
    input  logic     pop,
    input  cdb_pkt_t din,
    output logic     full,
    output logic     empty,
    output cdb_pkt_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    cdb_pkt_t        mem_q [DEPTH];
    cdb_pkt_t        mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == {CW{1'b0}});
    assign head      = mem_q[rd_ptr_q];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Next-state for storage, pointers and occupancy; flush empties the buffer.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: buffers results from each execution unit, picks one
// winner per cycle and drives the registered cdb_valid/tag/data/grant outputs.
// A result pushed at edge N is broadcast in the cycle after edge N+1.
// Build option CDB_RR_ARB_EN: round-robin arbitration instead of fixed
// priority (lowest source index wins).
module cdb_broadcaster
    import cdb_pkg::*;
#(
    parameter int NUM_SRC    = CDB_NUM_SRC,
    parameter int DATA_WIDTH = CDB_DATA_W,
    parameter int TAG_WIDTH  = CDB_TAG_W,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            flush,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]    src_tag,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
    output logic [NUM_SRC-1:0]              src_ready,
    output logic                            cdb_valid,
    output logic [TAG_WIDTH-1:0]            cdb_tag,
    output logic [DATA_WIDTH-1:0]           cdb_data,
    output logic [NUM_SRC-1:0]              cdb_grant
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]    push_s, pop_s, full_s, empty_s, grant_s;
    cdb_pkt_t              pkt_in_s [NUM_SRC];
    cdb_pkt_t              head_s   [NUM_SRC];
    cdb_pkt_t              win_pkt_s;
    logic [IW-1:0]         win_idx_s;
    logic [IW-1:0]         base_s;
    logic                  win_found_s;

    logic                  cdb_valid_q, cdb_valid_d;
    logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic [NUM_SRC-1:0]    cdb_grant_q, cdb_grant_d;

    assign src_ready = ~full_s;
    assign push_s    = src_valid & ~full_s;
    assign pop_s     = grant_s & {NUM_SRC{~flush}};

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_grant = cdb_grant_q;

    // Unpack the flat source buses into one packet per source.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            pkt_in_s[i].tag  = src_tag[i*TAG_WIDTH +: TAG_WIDTH];
            pkt_in_s[i].data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
        cdb_src_fifo #(
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .flush   (flush),
            .push    (push_s[gi]),
            .pop     (pop_s[gi]),
            .din     (pkt_in_s[gi]),
            .full    (full_s[gi]),
            .empty   (empty_s[gi]),
            .head    (head_s[gi])
        );
    end

`ifdef CDB_RR_ARB_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    assign base_s = rr_ptr_q;

    // Rotate priority to just past the last granted source; hold when idle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            rr_ptr_d = {IW{1'b0}};
        end else if (win_found_s) begin
            rr_ptr_d = (win_idx_s == IW'(NUM_SRC - 1)) ? {IW{1'b0}} : win_idx_s + IW'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q <= {IW{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign base_s = {IW{1'b0}};
`endif

    // Pick the first non-empty FIFO scanning upward from base_s.
    always_comb begin
        grant_s     = {NUM_SRC{1'b0}};
        win_idx_s   = {IW{1'b0}};
        win_found_s = 1'b0;
        win_pkt_s   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int idx;
            idx = (int'(base_s) + k) % NUM_SRC;
            if (!win_found_s && !empty_s[idx]) begin
                grant_s[idx] = 1'b1;
                win_idx_s    = IW'(idx);
                win_pkt_s    = head_s[idx];
                win_found_s  = 1'b1;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Broadcast next-state: tag/data hold when idle, valid/grant clear.
    always_comb begin
        cdb_valid_d = 1'b0;
        cdb_grant_d = {NUM_SRC{1'b0}};
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        if (flush) begin
            cdb_valid_d = 1'b0;
        end else if (win_found_s) begin
            cdb_valid_d = 1'b1;
            cdb_grant_d = grant_s;
            cdb_tag_d   = win_pkt_s.tag;
            cdb_data_d  = win_pkt_s.data;
        end else begin
            cdb_valid_d = 1'b0;
        end
    end

    // CDB output registers; async reset drops any broadcast in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= {TAG_WIDTH{1'b0}};
            cdb_data_q  <= {DATA_WIDTH{1'b0}};
            cdb_grant_q <= {NUM_SRC{1'b0}};
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_grant_q <= cdb_grant_d;
        end
    end

endmodule
